// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port byte-addressable memory block.
// Contents: byte width, width helpers, byte parity and read-latency legality check.
package mem_pkg;

  localparam int unsigned BYTE_W = 8;

  // Byte-address width for a DEPTH x WIDTH-byte array.
  function automatic int unsigned addr_w(input int unsigned depth, input int unsigned width);
    return $clog2(depth * width);
  endfunction

  // Byte-offset width inside one word.
  function automatic int unsigned off_w(input int unsigned width);
    return $clog2(width);
  endfunction

  // Word-index width.
  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Even parity of one byte.
  function automatic logic byte_par(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

  // Only single- and two-cycle read pipelines exist.
  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/mem_block_dp_if.sv
// Request/response bundle of mem_block_dp.
// Port A: req/we/addr/wdata/bytemask/pinj in, gnt/rvalid/rdata/perr out, rready in.
// Port B: req/addr in, gnt/rvalid/rdata/perr out, rready in.
// master = requester side, slave = memory side.
interface mem_block_dp_if
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned AW = addr_w(DEPTH, WIDTH);
  localparam int unsigned DW = BYTE_W * WIDTH;

  logic          a_req_i;
  logic          a_we_i;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i;
  logic [WIDTH-1:0] a_bytemask_i;
  logic          a_pinj_i;
  logic          a_gnt_o;
  logic          a_rvalid_o;
  logic [DW-1:0] a_rdata_o;
  logic          a_perr_o;
  logic          a_rready_i;

  logic          b_req_i;
  logic [AW-1:0] b_addr_i;
  logic          b_gnt_o;
  logic          b_rvalid_o;
  logic [DW-1:0] b_rdata_o;
  logic          b_perr_o;
  logic          b_rready_i;

  modport master (
    output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_bytemask_i, a_pinj_i, a_rready_i,
    output b_req_i, b_addr_i, b_rready_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o, a_perr_o,
    input  b_gnt_o, b_rvalid_o, b_rdata_o, b_perr_o
  );

  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_bytemask_i, a_pinj_i, a_rready_i,
    input  b_req_i, b_addr_i, b_rready_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o, a_perr_o,
    output b_gnt_o, b_rvalid_o, b_rdata_o, b_perr_o
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// Per-port read response pipeline of RD_LAT (1 or 2) stages.
// Ports: clk, rst_n_i; in_valid/in_data/in_perr from the array read;
// rready from the consumer; rvalid/rdata/perr registered response;
// stall_c = response held and not consumed (freezes the whole pipe).
module mem_rd_pipe #(
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_perr,
  input  logic          rready,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          perr,
  output logic          stall_c
);

  assign stall_c = rvalid && !rready;

  if (RD_LAT == 2) begin : g_lat2
    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_perr;

    // Both stages advance together; an empty output stage lets stage 1 drain.
    always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        s1_perr  <= 1'b0;
        rvalid   <= 1'b0;
        rdata    <= '0;
        perr     <= 1'b0;
      end else if (!stall_c) begin
        s1_valid <= in_valid;
        s1_data  <= in_data;
        s1_perr  <= in_perr;
        rvalid   <= s1_valid;
        rdata    <= s1_data;
        perr     <= s1_perr;
      end
    end
  end else begin : g_lat1
    // Single output stage, frozen while the response is held.
    always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rvalid <= 1'b0;
        rdata  <= '0;
        perr   <= 1'b0;
      end else if (!stall_c) begin
        rvalid <= in_valid;
        rdata  <= in_data;
        perr   <= in_perr;
      end
    end
  end

endmodule

// File: rtl/mem_block_dp.sv
// Dual-port byte-addressable SRAM: port A read/write, port B read-only.
// Ports: clk, rst_n_i (async, active-low), bus (mem_block_dp_if.slave).
// Reads are captured at the accept edge and returned after RD_LAT cycles
// with per-port backpressure; same-cycle A write / B read is write-first per byte.
// Optional: define MEM_PARITY_EN for one stored even-parity bit per byte.
module mem_block_dp
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n_i,
  mem_block_dp_if.slave  bus
);

  localparam int unsigned OW = off_w(WIDTH);
  localparam int unsigned IW = idx_w(DEPTH);
  localparam int unsigned DW = BYTE_W * WIDTH;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $fatal(1, "mem_block_dp: RD_LAT must be 1 or 2");
  end

  logic [DW-1:0] mem [DEPTH];

  logic [IW-1:0] a_idx;
  logic [IW-1:0] b_idx;
  logic          a_wr_c;
  logic          a_rd_c;
  logic          b_rd_c;
  logic          fwd_c;
  logic          a_stall_c;
  logic          b_stall_c;
  logic [DW-1:0] a_rword_c;
  logic [DW-1:0] b_rword_c;
  logic          a_perr_c;
  logic          b_perr_c;
  logic          unused_ok;

  assign a_idx = bus.a_addr_i[OW +: IW];
  assign b_idx = bus.b_addr_i[OW +: IW];

  // Writes never wait on the response path; nothing lands while in reset.
  assign a_wr_c = bus.a_req_i && bus.a_we_i && rst_n_i;
  assign a_rd_c = bus.a_req_i && !bus.a_we_i && !a_stall_c;
  assign b_rd_c = bus.b_req_i && !b_stall_c;
  assign fwd_c  = a_wr_c && (a_idx == b_idx);

  assign bus.a_gnt_o = (bus.a_req_i && bus.a_we_i) || !a_stall_c;
  assign bus.b_gnt_o = !b_stall_c;

  // Byte offset bits are don't-care; pinj only matters with parity storage.
  assign unused_ok = ^{bus.a_addr_i, bus.b_addr_i, bus.a_pinj_i};

`ifdef MEM_PARITY_EN
  logic [WIDTH-1:0] par_mem [DEPTH];
  logic [WIDTH-1:0] wpar_c;
  logic [WIDTH-1:0] a_pst_c;
  logic [WIDTH-1:0] b_pst_c;

  // Stored parity of each written byte, optionally inverted for error injection.
  always_comb begin : p_wpar
    wpar_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      wpar_c[i] = byte_par(bus.a_wdata_i[i*BYTE_W +: BYTE_W]) ^ bus.a_pinj_i;
    end
  end
`endif

  // Masked byte write.
  always_ff @(posedge clk) begin : p_wr
    if (a_wr_c) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (bus.a_bytemask_i[i]) begin
          mem[a_idx][i*BYTE_W +: BYTE_W] <= bus.a_wdata_i[i*BYTE_W +: BYTE_W];
`ifdef MEM_PARITY_EN
          par_mem[a_idx][i] <= wpar_c[i];
`endif
        end
      end
    end
  end

  // Array read for both ports; B sees port A's same-cycle write on masked bytes.
  always_comb begin : p_rd
    a_rword_c = mem[a_idx];
    b_rword_c = mem[b_idx];
    a_perr_c  = 1'b0;
    b_perr_c  = 1'b0;
`ifdef MEM_PARITY_EN
    a_pst_c   = par_mem[a_idx];
    b_pst_c   = par_mem[b_idx];
`endif
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (fwd_c && bus.a_bytemask_i[i]) begin
        b_rword_c[i*BYTE_W +: BYTE_W] = bus.a_wdata_i[i*BYTE_W +: BYTE_W];
`ifdef MEM_PARITY_EN
        b_pst_c[i] = wpar_c[i];
`endif
      end
    end
`ifdef MEM_PARITY_EN
    for (int i = 0; i < int'(WIDTH); i++) begin
      a_perr_c = a_perr_c | (byte_par(a_rword_c[i*BYTE_W +: BYTE_W]) ^ a_pst_c[i]);
      b_perr_c = b_perr_c | (byte_par(b_rword_c[i*BYTE_W +: BYTE_W]) ^ b_pst_c[i]);
    end
`endif
  end

  mem_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_a_pipe (
    .clk      (clk),
    .rst_n_i  (rst_n_i),
    .in_valid (a_rd_c),
    .in_data  (a_rword_c),
    .in_perr  (a_perr_c),
    .rready   (bus.a_rready_i),
    .rvalid   (bus.a_rvalid_o),
    .rdata    (bus.a_rdata_o),
    .perr     (bus.a_perr_o),
    .stall_c  (a_stall_c)
  );

  mem_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_b_pipe (
    .clk      (clk),
    .rst_n_i  (rst_n_i),
    .in_valid (b_rd_c),
    .in_data  (b_rword_c),
    .in_perr  (b_perr_c),
    .rready   (bus.b_rready_i),
    .rvalid   (bus.b_rvalid_o),
    .rdata    (bus.b_rdata_o),
    .perr     (bus.b_perr_o),
    .stall_c  (b_stall_c)
  );

endmodule

// File: tb/tb_mem_block_dp.sv
// Bench for mem_block_dp: one RD_LAT=1 and one RD_LAT=2 instance driven by the
// same stimulus, checked against a byte-level memory model with latency queues.
module tb_mem_block_dp;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned WIDTH = 4;
`ifdef MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, a_pinj, a_rready, b_req, b_rready;
  logic [10:0] a_addr, b_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_mask;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_block_dp_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) if1 ();
  mem_block_dp_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) if2 ();

  assign if1.a_req_i = a_req;       assign if2.a_req_i = a_req;
  assign if1.a_we_i = a_we;         assign if2.a_we_i = a_we;
  assign if1.a_addr_i = a_addr;     assign if2.a_addr_i = a_addr;
  assign if1.a_wdata_i = a_wdata;   assign if2.a_wdata_i = a_wdata;
  assign if1.a_bytemask_i = a_mask; assign if2.a_bytemask_i = a_mask;
  assign if1.a_pinj_i = a_pinj;     assign if2.a_pinj_i = a_pinj;
  assign if1.a_rready_i = a_rready; assign if2.a_rready_i = a_rready;
  assign if1.b_req_i = b_req;       assign if2.b_req_i = b_req;
  assign if1.b_addr_i = b_addr;     assign if2.b_addr_i = b_addr;
  assign if1.b_rready_i = b_rready; assign if2.b_rready_i = b_rready;

  mem_block_dp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n_i(rst_n), .bus(if1.slave));
  mem_block_dp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n_i(rst_n), .bus(if2.slave));

  // ---------------- model: bytes + per-channel response queues ----------------
  // channel 0: dut1 A, 1: dut1 B, 2: dut2 A, 3: dut2 B
  typedef struct {
    logic [31:0] d;
    bit          pe;
    int          age;
  } ent_t;

  logic [7:0] mm  [DEPTH][WIDTH];
  bit         cor [DEPTH][WIDTH];
  ent_t       fl  [4][4];
  int         cnt [4];

  function automatic int lat(input int c);
    return (c < 2) ? 1 : 2;
  endfunction

  function automatic logic [31:0] mword(input int w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = mm[w][b];
    return r;
  endfunction

  function automatic bit mperr(input int w);
    bit e;
    e = 1'b0;
    for (int b = 0; b < 4; b++) e = e | cor[w][b];
    return PAR && e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  task automatic get_out(input int c, output logic v, output logic [31:0] d,
                         output logic pe, output logic g);
    case (c)
      0: begin v = if1.a_rvalid_o; d = if1.a_rdata_o; pe = if1.a_perr_o; g = if1.a_gnt_o; end
      1: begin v = if1.b_rvalid_o; d = if1.b_rdata_o; pe = if1.b_perr_o; g = if1.b_gnt_o; end
      2: begin v = if2.a_rvalid_o; d = if2.a_rdata_o; pe = if2.a_perr_o; g = if2.a_gnt_o; end
      default: begin v = if2.b_rvalid_o; d = if2.b_rdata_o; pe = if2.b_perr_o; g = if2.b_gnt_o; end
    endcase
  endtask

  // Writes apply before reads in the same edge, which gives write-first for B.
  // A response becomes visible RD_LAT unstalled edges after its accept.
  initial begin : model
    bit vis, rr, acc;
    int w;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < 4; c++) cnt[c] = 0;
      end else begin
        if (a_req && a_we) begin
          w = int'(a_addr[10:2]);
          for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) begin
              mm[w][b]  = a_wdata[b*8 +: 8];
              cor[w][b] = a_pinj;
            end
          end
        end
        for (int c = 0; c < 4; c++) begin
          vis = (cnt[c] > 0) && (fl[c][0].age == lat(c));
          rr  = (c % 2 == 0) ? a_rready : b_rready;
          if (!(vis && !rr)) begin
            if (vis) begin
              for (int k = 0; k < cnt[c] - 1; k++) fl[c][k] = fl[c][k+1];
              cnt[c]--;
            end
            for (int k = 0; k < cnt[c]; k++) fl[c][k].age++;
            acc = (c % 2 == 0) ? (a_req && !a_we) : b_req;
            w   = (c % 2 == 0) ? int'(a_addr[10:2]) : int'(b_addr[10:2]);
            if (acc && cnt[c] < 4) begin
              fl[c][cnt[c]] = '{d: mword(w), pe: mperr(w), age: 1};
              cnt[c]++;
            end
          end
        end
      end
    end
  end

  // Every-cycle compare of valid/data/perr/grant against the model.
  initial begin : cmp
    logic v, pe, g;
    logic [31:0] d;
    bit ev, rr, eg;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        get_out(c, v, d, pe, g);
        ev = (cnt[c] > 0) && (fl[c][0].age == lat(c));
        rr = (c % 2 == 0) ? a_rready : b_rready;
        check($sformatf("ch%0d rvalid", c), 32'(v), 32'(ev));
        if (ev) begin
          check($sformatf("ch%0d rdata", c), d, fl[c][0].d);
          check($sformatf("ch%0d perr", c), 32'(pe), 32'(fl[c][0].pe));
        end
        eg = (c % 2 == 0) ? ((a_req && a_we) || !(ev && !rr)) : !(ev && !rr);
        check($sformatf("ch%0d gnt", c), 32'(g), 32'(eg));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_pinj = 1'b0; b_req = 1'b0;
  endtask

  task automatic wr(input logic [10:0] ad, input logic [31:0] d, input logic [3:0] m, input logic pj);
    a_req = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d; a_mask = m; a_pinj = pj;
  endtask

  task automatic rd_a(input logic [10:0] ad);
    a_req = 1'b1; a_we = 1'b0; a_addr = ad;
  endtask

  task automatic rd_b(input logic [10:0] ad);
    b_req = 1'b1; b_addr = ad;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] exp4 [8];
    rst_n = 1'b0;
    idle();
    a_addr = '0; b_addr = '0; a_wdata = '0; a_mask = '0;
    a_rready = 1'b1; b_rready = 1'b1;
    #12;
    check("rst dut1 a_rvalid", 32'(if1.a_rvalid_o), 32'd0);
    check("rst dut1 b_rvalid", 32'(if1.b_rvalid_o), 32'd0);
    check("rst dut2 a_rvalid", 32'(if2.a_rvalid_o), 32'd0);
    check("rst dut2 b_rvalid", 32'(if2.b_rvalid_o), 32'd0);
    check("rst dut1 a_rdata", if1.a_rdata_o, 32'd0);
    check("rst dut2 b_rdata", if2.b_rdata_o, 32'd0);
    check("rst dut1 a_perr", 32'(if1.a_perr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // preload words 0..7, word 8 (0x20) and word 12 (0x30)
    for (int i = 0; i < 8; i++) begin
      wr(11'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 1'b0);
      step();
    end
    wr(11'h20, 32'hAAAA_AAAA, 4'hF, 1'b0); step();
    wr(11'h30, 32'h0000_0000, 4'hF, 1'b0); step();

    // byte mask and read latency
    wr(11'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0); step();
    wr(11'h10, 32'h0000_5500, 4'b0010, 1'b0); step();
    idle(); rd_a(11'h10); step(); idle();
    check("t1 lat1 a_rvalid", 32'(if1.a_rvalid_o), 32'd1);
    check("t1 lat1 a_rdata", if1.a_rdata_o, 32'hDEAD_55EF);
    check("t1 lat2 a_rvalid early", 32'(if2.a_rvalid_o), 32'd0);
    step();
    check("t1 lat2 a_rvalid", 32'(if2.a_rvalid_o), 32'd1);
    check("t1 lat2 a_rdata", if2.a_rdata_o, 32'hDEAD_55EF);
    check("t1 lat1 single resp", 32'(if1.a_rvalid_o), 32'd0);
    step();

    // backpressure on B
    b_rready = 1'b0;
    rd_b(11'h10); step(); idle();
    for (int k = 0; k < 5; k++) begin
      check("t2 b_rvalid held", 32'(if1.b_rvalid_o), 32'd1);
      check("t2 b_gnt low", 32'(if1.b_gnt_o), 32'd0);
      check("t2 b_rdata stable", if1.b_rdata_o, 32'hDEAD_55EF);
      step();
    end
    check("t2 lat2 b_rvalid held", 32'(if2.b_rvalid_o), 32'd1);
    check("t2 lat2 b_rdata", if2.b_rdata_o, 32'hDEAD_55EF);
    b_rready = 1'b1;
    step();
    check("t2 lat1 drained", 32'(if1.b_rvalid_o), 32'd0);
    check("t2 lat2 drained", 32'(if2.b_rvalid_o), 32'd0);
    rd_b(11'h0);
    check("t2 lat1 next gnt", 32'(if1.b_gnt_o), 32'd1);
    check("t2 lat2 next gnt", 32'(if2.b_gnt_o), 32'd1);
    step(); idle(); step(); step();

    // same-cycle A write / B read collision
    wr(11'h20, 32'h1122_3344, 4'b0011, 1'b0);
    rd_b(11'h20);
    step(); idle();
    check("t3 collide lat1", if1.b_rdata_o, 32'hAAAA_3344);
    step();
    check("t3 collide lat2", if2.b_rdata_o, 32'hAAAA_3344);
    rd_b(11'h20); step(); idle();
    check("t3 reread", if1.b_rdata_o, 32'hAAAA_3344);
    step(); step();

    // back-to-back B reads
    for (int i = 0; i < 8; i++) exp4[i] = 32'hA000_0000 + 32'(i);
    exp4[4] = 32'hDEAD_55EF;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rd_b(11'(i * 4));
      else idle();
      step();
      if (i < 8) begin
        check("t4 lat1 valid", 32'(if1.b_rvalid_o), 32'd1);
        check("t4 lat1 data", if1.b_rdata_o, exp4[i]);
      end
      if (i > 0) begin
        check("t4 lat2 valid", 32'(if2.b_rvalid_o), 32'd1);
        check("t4 lat2 data", if2.b_rdata_o, exp4[i-1]);
      end else begin
        check("t4 lat2 first idle", 32'(if2.b_rvalid_o), 32'd0);
      end
    end
    step(); step();

    // reset with reads in flight; write during reset is dropped
    rd_a(11'h10); step(); idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 lat1 rvalid drop", 32'(if1.a_rvalid_o), 32'd0);
    check("t5 lat2 rvalid drop", 32'(if2.a_rvalid_o), 32'd0);
    wr(11'h10, 32'hFFFF_FFFF, 4'hF, 1'b0);
    step(); step(); idle();
    #3;
    rst_n = 1'b1;
    step(); step(); step();
    check("t5 no late resp", 32'(if2.a_rvalid_o), 32'd0);
    rd_a(11'h10); step(); idle();
    check("t5 preserved lat1", if1.a_rdata_o, 32'hDEAD_55EF);
    step();
    check("t5 preserved lat2", if2.a_rdata_o, 32'hDEAD_55EF);
    step();

    // parity inject
    wr(11'h30, 32'h1234_5678, 4'b0100, 1'b1); step(); idle();
    rd_a(11'h30); step(); idle();
    check("t6 inj rdata", if1.a_rdata_o, 32'h0034_0000);
    check("t6 inj perr lat1", 32'(if1.a_perr_o), 32'(PAR));
    step();
    check("t6 inj perr lat2", 32'(if2.a_perr_o), 32'(PAR));
    wr(11'h30, 32'h1234_5678, 4'b0100, 1'b0); step(); idle();
    rd_a(11'h30); step(); idle();
    check("t6 clean perr", 32'(if1.a_perr_o), 32'd0);
    step();
    wr(11'h30, 32'h1234_5678, 4'b0100, 1'b1);
    rd_b(11'h30);
    step(); idle();
    check("t6 collide perr", 32'(if1.b_perr_o), 32'(PAR));
    check("t6 collide rdata", if1.b_rdata_o, 32'h0034_0000);
    step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_block_dp.md
Name: mem_block_dp

Overview:
Dual-port byte-addressable SRAM block with request/grant and response valid/ready handshakes. It is the parametrised successor of the single-port masked memory.
- Port A: read/write; instruction/data side.
- Port B: read-only; e.g. debug or DMA read.
- Adds configurable read latency, response backpressure, a defined write/read collision policy and optional per-byte parity.

Parameters:
DEPTH, 512, number of words.
WIDTH, 4, bytes per word; data width is 8*WIDTH.
RD_LAT, 1, read latency in cycles; legal values 1 or 2. Any other value is a fatal elaboration error.

Ports:
clk  input  1  clock
rst_n_i  input  1  reset
a_req_i  input  1  port A request valid
a_we_i  input  1  port A write (1) / read (0)
a_addr_i  input  $clog2(DEPTH*WIDTH)  port A byte address; low $clog2(WIDTH) bits ignored
a_wdata_i  input  8*WIDTH  write data
a_bytemask_i  input  WIDTH  per-byte write enable
a_pinj_i  input  1  parity-inject for written bytes (test hook)
a_gnt_o  output  1  port A request accepted this cycle
a_rvalid_o  output  1  port A read response valid
a_rdata_o  output  8*WIDTH  port A read data
a_perr_o  output  1  port A parity error, qualified by a_rvalid_o
a_rready_i  input  1  port A response consumed
b_req_i  input  1  port B read request
b_addr_i  input  $clog2(DEPTH*WIDTH)  port B byte address
b_gnt_o  output  1  port B request accepted
b_rvalid_o  output  1  port B response valid
b_rdata_o  output  8*WIDTH  port B read data
b_perr_o  output  1  port B parity error
b_rready_i  input  1  port B response consumed

Behaviour:
Reset and clocking:
- Reset rst_n_i, asynchronous, active-low; clock clk.
- Reset values: all rvalid, rdata and perr outputs = 0; internal pipeline valids = 0.
- Memory array is not reset.

Grant and stall:
- Per port, stall = rvalid_o && !rready_i.
- gnt_o = !stall for reads.
- Port A writes are always granted (a_gnt_o = 1 when a_req_i && a_we_i), independent of stall.

Transfers:
- Accept = req && gnt at a rising edge.
- Read: the array word is captured at the accept edge.
- Write: bytes with bytemask=1 are updated at the accept edge.

Latency:
- RD_LAT=1: rvalid asserts the cycle after accept.
- RD_LAT=2: rvalid asserts two cycles after accept, via a stage-1 register plus an output register.
- Full throughput: one read per cycle while rready=1.

Backpressure:
- On stall the whole port pipeline freezes.
- rdata/perr stay stable while rvalid && !rready.
- No response is dropped or duplicated.
- RD_LAT=2 bubble collapse: if the output register is empty, stage 1 advances even when no new request arrives.

Ordering and collisions:
- Responses return in acceptance order per port.
- A write followed by a read to the same address, next cycle or later, returns the new data.
- Same-cycle port A write and port B read to the same word: write-first per byte. Masked bytes return new data; unmasked bytes return old data.
- A single port issues one operation per cycle, so there is no intra-port collision.

Reset mid-operation:
- In-flight reads are discarded; rvalid drops asynchronously.
- No response is issued after reset release.
- Writes presented while rst_n_i=0 are ignored; stored contents are preserved.

Optional Feature:
MEM_PARITY_EN
- With the macro defined:
  - One even-parity bit is stored per byte; stored value = XOR of the byte, inverted when a_pinj_i=1 for masked bytes.
  - On read, parity is recomputed per byte; perr = OR of mismatches, aligned with rdata through the same pipeline.
- Without the macro:
  - No parity storage.
  - a_perr_o = b_perr_o = 0 constant; a_pinj_i is ignored.

Decomposition:
- Shared package mem_pkg:
  - BYTE_W=8 constant.
  - Byte-parity function.
  - Address/word-index width helper localparams.
  - RD_LAT legal-value check.
- Sub-module mem_rd_pipe:
  - Per-port response pipeline of RD_LAT stages with freeze/bubble-collapse.
  - Carries data and perr; outputs rvalid/rdata/perr and a stall signal.
  - Instantiated twice.

Test Plan:
1. Byte mask: A write 0xDEADBEEF @0x10 mask 1111, then 0x00005500 mask 0010, then A read @0x10 -> a_rdata_o=0xDEAD55EF, a_rvalid_o exactly RD_LAT cycles after accept.
2. Backpressure: hold b_rready_i=0, B read @0x10 -> b_rvalid_o=1, b_gnt_o=0, b_rdata_o stable for 5 cycles. Release -> exactly one response, next read granted.
3. Collision: word @0x20 = 0xAAAAAAAA; same cycle A write 0x11223344 mask 0011 and B read @0x20 -> b_rdata_o=0xAAAA3344; subsequent read -> 0xAAAA3344.
4. Throughput: 8 back-to-back B reads of preloaded addresses 0x0..0x1C, rready=1, for RD_LAT=1 and RD_LAT=2 -> 8 in-order responses on 8 consecutive cycles.
5. Reset mid-read: assert rst_n_i with a read in flight -> rvalid=0 immediately, no response after release; previously written 0xDEAD55EF @0x10 still reads back.
6. Parity (MEM_PARITY_EN): A write 0x12345678 mask 0100 with a_pinj_i=1, read -> a_perr_o=1. Rewrite with a_pinj_i=0, read -> a_perr_o=0. Without the macro -> perr always 0.
